// File: rtl/mem6809_responder.sv
// mem6809_responder: RAM, reset vector, TX FIFO and cycle counter
// Optional: MEM6809_CYCLE_COUNTER_EN enables the cnt/snap I/O registers.
module mem6809_responder #(
  parameter int          RAM_AW       = 15,
  parameter logic [15:0] RESET_VECTOR = 16'h8000,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rw_n,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  input  logic        ld_en,
  input  logic [15:0] ld_addr,
  input  logic [7:0]  ld_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [7:0]    r_mem  [2**RAM_AW];
  logic [7:0]    r_fifo [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [4:0]    r_count;
  logic          r_ovf;

  logic          w_ram_sel;
  logic          w_wr;
  logic          w_push;
  logic          w_pop;
  logic          w_push_ok;
  logic          w_empty;
  logic          w_full;
  logic [7:0]    w_status;
  logic [7:0]    w_rdata;
  logic          w_unused_ld;

  // Load port only sees the RAM mirror; upper address bits are don't-care
  assign w_unused_ld = ^ld_addr[15:RAM_AW];

  assign w_ram_sel = (cpu_addr < 16'hF000);
  assign w_wr      = ~cpu_rw_n;
  assign w_push    = w_wr & (cpu_addr == 16'hF000);
  assign w_empty   = (r_count == 5'd0);
  assign w_full    = (r_count == 5'(FIFO_DEPTH));
  assign w_pop     = ~w_empty & tx_ready;
  assign w_push_ok = w_push & (~w_full | w_pop);
  assign w_status  = {r_count[3:0], 1'b0, r_ovf, w_empty, w_full};

  assign tx_valid  = ~w_empty;
  assign tx_data   = w_empty ? 8'h00 : r_fifo[r_rd_ptr];

`ifdef MEM6809_CYCLE_COUNTER_EN
  logic [15:0] r_cnt;
  logic [7:0]  r_snap;
  logic        w_cnt_rd;

  assign w_cnt_rd = cpu_rw_n & (cpu_addr == 16'hF002);

  // Free-running counter; a CNT_HI read captures the low byte
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_cnt  <= 16'h0000;
      r_snap <= 8'h00;
    end else begin
      r_cnt <= r_cnt + 16'h0001;
      if (w_cnt_rd) r_snap <= r_cnt[7:0];
    end
  end
`endif

  // RAM commit: load port wins over a same-cycle core write
  always_ff @(posedge clk) begin
    if (ld_en) begin
      r_mem[ld_addr[RAM_AW-1:0]] <= ld_data;
    end else if (w_wr & w_ram_sel) begin
      r_mem[cpu_addr[RAM_AW-1:0]] <= cpu_wdata;
    end
  end

  // FIFO storage, written only when a push is accepted
  always_ff @(posedge clk) begin
    if (w_push_ok) r_fifo[r_wr_ptr] <= cpu_wdata;
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= 5'd0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 5'd1;
        2'b01:   r_count <= r_count - 5'd1;
        default: r_count <= r_count;
      endcase
      if (w_push & ~w_push_ok) begin
        r_ovf <= 1'b1;
      end else if (w_wr & (cpu_addr == 16'hF001)) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // Zero-latency read decode
  always_comb begin
    w_rdata = 8'h00;
    if (w_ram_sel) begin
      w_rdata = r_mem[cpu_addr[RAM_AW-1:0]];
    end else begin
      case (cpu_addr)
        16'hF001: w_rdata = w_status;
`ifdef MEM6809_CYCLE_COUNTER_EN
        16'hF002: w_rdata = r_cnt[15:8];
        16'hF003: w_rdata = r_snap;
`endif
        16'hFFFE: w_rdata = RESET_VECTOR[15:8];
        16'hFFFF: w_rdata = RESET_VECTOR[7:0];
        default:  w_rdata = 8'h00;
      endcase
    end
  end

  assign cpu_rdata = w_rdata;

endmodule

// File: tb/tb_mem6809_responder.sv
// tb_mem6809_responder: directed checks for mem6809_responder
// Honours MEM6809_CYCLE_COUNTER_EN the same way the design does.
module tb_mem6809_responder;

  logic        clk;
  logic        reset_b;
  logic [15:0] cpu_addr;
  logic        cpu_rw_n;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        ld_en;
  logic [15:0] ld_addr;
  logic [7:0]  ld_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  int n_chk;
  int n_fail;

  mem6809_responder #(
    .RAM_AW      (12),
    .RESET_VECTOR(16'h8000),
    .FIFO_DEPTH  (8)
  ) dut (
    .clk      (clk),
    .reset_b  (reset_b),
    .cpu_addr (cpu_addr),
    .cpu_rw_n (cpu_rw_n),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .ld_en    (ld_en),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [15:0] got,
                       input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One write cycle, called at a negedge, returns at the next negedge
  task automatic bus_wr(input logic [15:0] a, input logic [7:0] d);
    cpu_addr  = a;
    cpu_rw_n  = 1'b0;
    cpu_wdata = d;
    @(negedge clk);
    cpu_rw_n  = 1'b1;
    cpu_addr  = 16'hF004;
  endtask

  // One read cycle with check, called at a negedge
  task automatic check_rd(input string tag,
                          input logic [15:0] a,
                          input logic [7:0] exp);
    cpu_addr = a;
    cpu_rw_n = 1'b1;
    #1;
    check(tag, {8'h00, cpu_rdata}, {8'h00, exp});
    @(negedge clk);
    cpu_addr = 16'hF004;
  endtask

  logic [7:0] drain_exp [8];

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    reset_b   = 1'b0;
    cpu_addr  = 16'hFFFE;
    cpu_rw_n  = 1'b1;
    cpu_wdata = 8'h00;
    ld_en     = 1'b0;
    ld_addr   = 16'h0000;
    ld_data   = 8'h00;
    tx_ready  = 1'b0;

    #1;
    check("rst_vec_hi", {8'h00, cpu_rdata}, 16'h0080);
    check("rst_valid", {15'h0, tx_valid}, 16'h0000);
    check("rst_data", {8'h00, tx_data}, 16'h0000);
    cpu_addr = 16'hF001;
    #1;
    check("rst_status", {8'h00, cpu_rdata}, 16'h0002);
    @(negedge clk);
    @(negedge clk);
    reset_b = 1'b1;

    check_rd("vec_hi", 16'hFFFE, 8'h80);
    check_rd("vec_lo", 16'hFFFF, 8'h00);
    bus_wr(16'hFFFE, 8'h12);
    check_rd("vec_ro", 16'hFFFE, 8'h80);
    check_rd("txdata_rd", 16'hF000, 8'h00);
    check_rd("io_hole", 16'hFFFD, 8'h00);

    ld_en   = 1'b1;
    ld_addr = 16'h1234;
    ld_data = 8'hA5;
    @(negedge clk);
    ld_en = 1'b0;
    check_rd("mirror_5234", 16'h5234, 8'hA5);
    check_rd("mirror_e234", 16'hE234, 8'hA5);

    bus_wr(16'h0010, 8'h3C);
    check_rd("core_wr", 16'h0010, 8'h3C);
    check_rd("core_mirror", 16'h1010, 8'h3C);

    ld_en   = 1'b1;
    ld_addr = 16'h0020;
    ld_data = 8'h77;
    bus_wr(16'h0020, 8'h11);
    ld_en = 1'b0;
    check_rd("ld_prio", 16'h0020, 8'h77);

    bus_wr(16'hF000, 8'h41);
    bus_wr(16'hF000, 8'h42);
    bus_wr(16'hF000, 8'h43);
    check_rd("flow_status", 16'hF001, 8'h30);
    check("flow_head", {8'h00, tx_data}, 16'h0041);
    tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("flow_pop%0d", i),
            {8'h00, tx_data}, 16'h0041 + 16'(i));
      @(negedge clk);
    end
    tx_ready = 1'b0;
    #1;
    check("flow_valid0", {15'h0, tx_valid}, 16'h0000);
    check_rd("flow_empty", 16'hF001, 8'h02);

    for (int i = 0; i < 9; i++) bus_wr(16'hF000, 8'h50 + 8'(i));
    check_rd("ovf_status", 16'hF001, 8'h85);
    check("ovf_head", {8'h00, tx_data}, 16'h0050);
    tx_ready = 1'b1;
    bus_wr(16'hF000, 8'h60);
    tx_ready = 1'b0;
    check_rd("pushpop_full", 16'hF001, 8'h85);
    for (int i = 0; i < 7; i++) drain_exp[i] = 8'h51 + 8'(i);
    drain_exp[7] = 8'h60;
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check($sformatf("drain%0d", i),
            {8'h00, tx_data}, {8'h00, drain_exp[i]});
      @(negedge clk);
    end
    tx_ready = 1'b0;
    #1;
    check("drain_valid0", {15'h0, tx_valid}, 16'h0000);
    check_rd("ovf_kept", 16'hF001, 8'h06);
    bus_wr(16'hF001, 8'hFF);
    check_rd("ovf_clear", 16'hF001, 8'h02);

    bus_wr(16'hF000, 8'h99);
    #1;
    check("mid_valid", {15'h0, tx_valid}, 16'h0001);
    reset_b = 1'b0;
    cpu_addr = 16'hF001;
    #1;
    check("mid_rst_valid", {15'h0, tx_valid}, 16'h0000);
    check("mid_rst_data", {8'h00, tx_data}, 16'h0000);
    check("mid_rst_status", {8'h00, cpu_rdata}, 16'h0002);
    @(negedge clk);
    cpu_addr = 16'hF004;
    check_rd("ram_survives", 16'h0010, 8'h3C);
    reset_b = 1'b1;

`ifdef MEM6809_CYCLE_COUNTER_EN
    repeat (16'h1233) @(negedge clk);
    check_rd("cnt_hi", 16'hF002, 8'h12);
    check_rd("cnt_snap", 16'hF003, 8'h33);
    repeat (16'hFFFF - 16'h1235) @(negedge clk);
    check_rd("cnt_ffff", 16'hF002, 8'hFF);
    check_rd("snap_ff", 16'hF003, 8'hFF);
    check_rd("cnt_wrap", 16'hF002, 8'h00);
`else
    repeat (20) @(negedge clk);
    check_rd("cnt_off_hi", 16'hF002, 8'h00);
    check_rd("cnt_off_lo", 16'hF003, 8'h00);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
